// File: rtl/mealy_101_if.sv
// Serial detector bus: one input bit in, Mealy flag, matched-prefix state and detection count out.
interface mealy_101_if #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned COUNT_W = 8
);
  localparam int unsigned W = $clog2(PAT_LEN);

  logic               in;
  logic               out;
  logic [W-1:0]       state;
  logic [COUNT_W-1:0] det_count;

  modport master (output in, input out, input state, input det_count);
  modport slave  (input in, output out, output state, output det_count);
endinterface

// File: rtl/mealy_101.sv
// Overlapping Mealy pattern detector; transition table derived from the pattern's KMP failure function.
module mealy_101 #(
  parameter int unsigned          PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0]   PATTERN = 3'b101,
  parameter int unsigned          COUNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mealy_101_if.slave  bus
);
  localparam int unsigned W  = $clog2(PAT_LEN);
  localparam int unsigned NS = 2 ** W;

  // Longest proper pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic int unsigned kmp_next(int unsigned k, logic b);
    logic [PAT_LEN:0] seq;
    int unsigned      n;
    int unsigned      best;
    logic             ok;
    seq  = '0;
    n    = k + 1;
    best = 0;
    for (int unsigned i = 0; i < k; i++) seq[i] = PATTERN[PAT_LEN-1-i];
    seq[k] = b;
    for (int unsigned len = 1; len < PAT_LEN && len <= n; len++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < len; j++)
        if (seq[n-len+j] != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
      if (ok) best = len;
    end
    return best;
  endfunction

  logic [W-1:0] nxt0 [NS];
  logic [W-1:0] nxt1 [NS];

  // Unreachable encodings (NS > PAT_LEN) fall back to state 0.
  for (genvar k = 0; k < NS; k++) begin : g_tab
    if (k < PAT_LEN) begin : g_live
      assign nxt0[k] = W'(kmp_next(k, 1'b0));
      assign nxt1[k] = W'(kmp_next(k, 1'b1));
    end else begin : g_dead
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  logic [W-1:0]       state_q;
  logic [W-1:0]       state_d;
  logic [COUNT_W-1:0] count_q;
  logic               hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (hit && count_q != '1) count_q <= count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d = bus.in ? nxt1[state_q] : nxt0[state_q];
  end

  always_comb begin
    hit = 1'b0;
    if (!rst && state_q == W'(PAT_LEN - 1) && bus.in == PATTERN[0]) hit = 1'b1;
  end

  assign bus.out       = hit;
  assign bus.state     = state_q;
  assign bus.det_count = count_q;
endmodule

// File: tb/tb_mealy_101.sv
// Random and directed bench for mealy_101: three instances checked against a bit-history reference model.
module tb_mealy_101;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  always #5 clk = ~clk;

  mealy_101_if #(.PAT_LEN(3), .COUNT_W(8)) if0 ();
  mealy_101_if #(.PAT_LEN(3), .COUNT_W(3)) if1 ();
  mealy_101_if #(.PAT_LEN(4), .COUNT_W(8)) if2 ();

  assign if0.in = din;
  assign if1.in = din;
  assign if2.in = din;

  mealy_101 #(.PAT_LEN(3), .PATTERN(3'b101),  .COUNT_W(8)) d0 (.clk(clk), .rst(rst), .bus(if0));
  mealy_101 #(.PAT_LEN(3), .PATTERN(3'b101),  .COUNT_W(3)) d1 (.clk(clk), .rst(rst), .bus(if1));
  mealy_101 #(.PAT_LEN(4), .PATTERN(4'b1011), .COUNT_W(8)) d2 (.clk(clk), .rst(rst), .bus(if2));

  localparam int unsigned LEN  [3] = '{3, 3, 4};
  localparam int unsigned PAT  [3] = '{5, 5, 11};
  localparam int unsigned CMAX [3] = '{255, 7, 255};

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned sr      = 0;
  int unsigned nbits   = 0;
  int unsigned cnt [3] = '{0, 0, 0};
  bit          armed   = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Detect when the last len bits received since reset spell the pattern.
  function automatic bit exp_out(int unsigned len, int unsigned pat, bit b);
    int unsigned v;
    int unsigned mask;
    if (nbits + 1 < len) return 1'b0;
    v    = (sr << 1) | 32'(b);
    mask = (32'd1 << len) - 1;
    return (v & mask) == pat;
  endfunction

  // Longest proper pattern prefix equal to the most recent bits since reset.
  function automatic int unsigned exp_state(int unsigned len, int unsigned pat);
    for (int unsigned l = len - 1; l > 0; l--)
      if (l <= nbits && (sr & ((32'd1 << l) - 1)) == (pat >> (len - l))) return l;
    return 0;
  endfunction

  task automatic step(bit b, bit r);
    bit eo [3];
    @(negedge clk);
    din = b;
    rst = r;
    #1;
    for (int i = 0; i < 3; i++) eo[i] = !r && exp_out(LEN[i], PAT[i], b);
    if (armed) begin
      check("out0",   32'(if0.out),       32'(eo[0]));
      check("out1",   32'(if1.out),       32'(eo[1]));
      check("out2",   32'(if2.out),       32'(eo[2]));
      check("cnt0",   32'(if0.det_count), cnt[0]);
      check("cnt1",   32'(if1.det_count), cnt[1]);
      check("cnt2",   32'(if2.det_count), cnt[2]);
      check("state0", 32'(if0.state),     exp_state(LEN[0], PAT[0]));
      check("state2", 32'(if2.state),     exp_state(LEN[2], PAT[2]));
    end
    if (r) begin
      sr    = 0;
      nbits = 0;
      cnt   = '{0, 0, 0};
      armed = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) if (eo[i] && cnt[i] < CMAX[i]) cnt[i]++;
      sr = (sr << 1) | 32'(b);
      nbits++;
    end
  endtask

  task automatic run_seq(logic [31:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0);
  endtask

  // Absolute expectations after a directed sequence, then two reset cycles.
  task automatic end_test(string tag, int unsigned c0, int unsigned c1, int unsigned c2, int unsigned s0);
    @(posedge clk);
    #1;
    check({tag, "_cnt0"},   32'(if0.det_count), c0);
    check({tag, "_cnt1"},   32'(if1.det_count), c1);
    check({tag, "_cnt2"},   32'(if2.det_count), c2);
    check({tag, "_state0"}, 32'(if0.state),     s0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    run_seq(32'b101, 3);
    end_test("t1", 1, 1, 0, 1);
    run_seq(32'b10101, 5);
    end_test("t2", 2, 2, 0, 1);
    run_seq(32'b1101, 4);
    end_test("t3a", 1, 1, 0, 1);
    run_seq(32'b1001, 4);
    end_test("t3b", 0, 0, 0, 1);

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    end_test("t4", 0, 0, 0, 1);

    run_seq(32'hAAAAA, 20);
    end_test("t5", 9, 7, 0, 2);
    run_seq(32'b1011011, 7);
    end_test("t6", 2, 2, 2, 1);

    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
